ro_window_counter: RTL and testbench

Multi-channel gated edge counter for ring-oscillator PUF measurement. Counts rising edges of NUM_CH oscillator outputs over a programmable window of clk cycles, started by a request. Reports one count per channel with a done pulse. Sits between the RO array and the response-extraction / readout logic. Generalises the single-channel counter with a window timer, start/busy/done handshake, saturation and overflow flags.

---
 rtl/ro_window_counter.sv | 74 +++++++
 tb/tb_ro_window_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ro_window_counter.sv
// ro_window_counter: windowed multi-channel RO edge counter with saturation; RO_PAIR_COMPARE_EN adds pairwise response bits
module ro_window_counter #(
  parameter int NUM_CH = 4,
  parameter int NUM_BITS = 32,
  parameter int WIN_BITS = 24
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NUM_CH-1:0]          signal_in,
  input  logic                       enable,
  input  logic                       start,
  input  logic [WIN_BITS-1:0]        window_len,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH*NUM_BITS-1:0] count,
  output logic [NUM_CH-1:0]          overflow
`ifdef RO_PAIR_COMPARE_EN
  ,
  output logic [NUM_CH/2-1:0]        response
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;
  state_t state, nxt;
  logic [WIN_BITS-1:0] len, timer;
  logic [NUM_CH-1:0] sync1, sync2, sync3, pulse;
  logic [NUM_CH-1:0][NUM_BITS-1:0] cnt;
  assign pulse = sync2 & ~sync3;
  assign busy = state == S_ARM || state == S_COUNT;
  assign done = state == S_DONE;
  assign count = cnt;
  always_comb begin
    nxt = state == S_IDLE  ? (start ? S_ARM : S_IDLE) :
          state == S_ARM   ? (len != '0 ? S_COUNT : S_DONE) :
          state == S_COUNT ? (enable && timer == WIN_BITS'(1) ? S_DONE : S_COUNT) :
                             S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= S_IDLE;
      len <= '0;
      timer <= '0;
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      state <= nxt;
      {sync3, sync2, sync1} <= {sync2, sync1, signal_in};
      if (state == S_IDLE && start) len <= window_len;
      if (state == S_ARM) timer <= len;
      else if (state == S_COUNT && enable) timer <= timer - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (arst || state == S_ARM) begin
        cnt[i] <= '0;
        overflow[i] <= 1'b0;
      end else if (state == S_COUNT && enable && pulse[i]) begin
        if (&cnt[i]) overflow[i] <= 1'b1;
        else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`ifdef RO_PAIR_COMPARE_EN
  if (NUM_CH % 2 != 0) begin : g_odd
    $error("ro_window_counter: NUM_CH must be even with RO_PAIR_COMPARE_EN");
  end
  always_ff @(posedge clk) begin
    if (arst) response <= '0;
    else if (state == S_DONE)
      for (int k = 0; k < NUM_CH/2; k++) response[k] <= cnt[2*k] > cnt[2*k+1];
  end
`endif
endmodule

// File: tb/tb_ro_window_counter.sv
// tb_ro_window_counter: directed checks of window timing, gating, saturation, handshake and reset
module tb_ro_window_counter;
  logic clk = 1'b0, arst = 1'b1, enable = 1'b1, start = 1'b0;
  logic [3:0] signal_in = '0;
  logic [23:0] window_len = '0;
  logic busy, done, busy4, done4;
  logic [127:0] count;
  logic [15:0] count4;
  logic [3:0] overflow, overflow4;
`ifdef RO_PAIR_COMPARE_EN
  logic [1:0] response, response4;
`endif
  int checks = 0, failures = 0, gph = 0;
  int per[4] = '{4, 6, 8, 10};
  logic gen_on = 1'b0;
  int first, pulses;
  logic b_one, b_rst;

  ro_window_counter dut (
    .clk(clk), .arst(arst), .signal_in(signal_in), .enable(enable), .start(start),
    .window_len(window_len), .busy(busy), .done(done), .count(count), .overflow(overflow)
`ifdef RO_PAIR_COMPARE_EN
    , .response(response)
`endif
  );

  ro_window_counter #(.NUM_CH(4), .NUM_BITS(4), .WIN_BITS(24)) dut4 (
    .clk(clk), .arst(arst), .signal_in(signal_in), .enable(enable), .start(start),
    .window_len(window_len), .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
`ifdef RO_PAIR_COMPARE_EN
    , .response(response4)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (gen_on) begin
      for (int c = 0; c < 4; c++) signal_in[c] = (gph % per[c]) < per[c] / 2;
      gph++;
    end else signal_in = '0;
  endtask

  task automatic begin_meas(input int len, input int p0, input int p1, input int p2, input int p3);
    gen_on = 1'b0;
    start = 1'b0;
    repeat (4) tick();
    per = '{p0, p1, p2, p3};
    gph = 0;
    gen_on = 1'b1;
    tick();
    start = 1'b1;
    window_len = 24'(len);
    enable = 1'b1;
  endtask

  task automatic run(input int n, input int lo, input int hi, input int st_at, input int rst_at,
                     output int first_done, output int npulse, output logic b1, output logic br);
    first_done = -1;
    npulse = 0;
    b1 = 1'b0;
    br = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (done) begin
        npulse++;
        if (first_done < 0) first_done = i;
      end
      if (i == 1) b1 = busy;
      if (i == rst_at + 1) br = busy;
      start = (i == st_at);
      arst = (i == rst_at);
      enable = !(i >= lo && i < hi);
      window_len = 24'd7;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ovf4", overflow4, 0);
`ifdef RO_PAIR_COMPARE_EN
    chk("rst_resp", response, 0);
`endif
    arst = 1'b0;
    begin_meas(100, 4, 6, 8, 10);
    run(110, 0, 0, 0, 0, first, pulses, b_one, b_rst);
    chk("basic_done_at", first, 102);
    chk("basic_pulses", pulses, 1);
    chk("basic_busy1", b_one, 1);
    chk("basic_c0", count[0 +: 32], 25);
    chk("basic_c1", count[32 +: 32], 17);
    chk("basic_c2", count[64 +: 32], 13);
    chk("basic_c3", count[96 +: 32], 10);
    chk("basic_ovf", overflow, 0);
    chk("sat_count4", count4, 16'hADFF);
    chk("sat_ovf4", overflow4, 4'b0011);
    begin_meas(0, 4, 6, 8, 10);
    run(6, 0, 0, 0, 0, first, pulses, b_one, b_rst);
    chk("zero_done_at", first, 2);
    chk("zero_pulses", pulses, 1);
    chk("zero_busy1", b_one, 1);
    chk("zero_count", count, 0);
    chk("zero_ovf4_clr", overflow4, 0);
    chk("zero_count4", count4, 0);
    begin_meas(50, 4, 6, 8, 10);
    run(90, 20, 40, 10, 0, first, pulses, b_one, b_rst);
    chk("gate_done_at", first, 72);
    chk("gate_pulses", pulses, 1);
    chk("gate_c0", count[0 +: 32], 13);
    chk("gate_c3", count[96 +: 32], 5);
    begin_meas(100, 4, 4, 4, 4);
    run(200, 0, 0, 0, 90, first, pulses, b_one, b_rst);
    chk("abort_no_done", pulses, 0);
    chk("abort_busy", b_rst, 0);
    chk("abort_count", count, 0);
    chk("abort_count4", count4, 0);
    chk("abort_ovf4", overflow4, 0);
`ifdef RO_PAIR_COMPARE_EN
    begin_meas(64, 4, 8, 6, 6);
    run(80, 0, 0, 0, 0, first, pulses, b_one, b_rst);
    chk("pair_done_at", first, 66);
    chk("pair_c0", count[0 +: 32], 16);
    chk("pair_c1", count[32 +: 32], 8);
    chk("pair_c2", count[64 +: 32], 11);
    chk("pair_resp", response, 2'b01);
    chk("pair_resp4", response4, 2'b01);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
